// File: rtl/norm_round_pipe_if.sv
// Handshake bundle between the four-input mantissa adder and the normalise/round stage.
// The slave side is the rounding pipe; the master side is the producer plus the result consumer.
interface norm_round_pipe_if #(
    parameter int expWidth   = 4,
    parameter int sigWidth   = 4,
    parameter int low_expand = 2
);
    localparam int W = sigWidth + 4 + low_expand;

    logic                         in_valid;
    logic                         in_ready;
    logic [W-1:0]                 in_mantissa;
    logic [expWidth-1:0]          in_exp;
    logic                         out_valid;
    logic                         out_ready;
    logic [expWidth+sigWidth-1:0] out_result;
    logic [2:0]                   out_flags;

    modport master (
        output in_valid, in_mantissa, in_exp, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_mantissa, in_exp, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/norm_round_pipe.sv
// Three-stage normalise / round-to-nearest-even / saturate pipe that turns the raw
// two's-complement adder sum and shared exponent into a packed {sign, exp, frac} float.
module norm_round_pipe #(
    parameter int expWidth   = 4,
    parameter int sigWidth   = 4,
    parameter int low_expand = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    norm_round_pipe_if.slave bus
);
    localparam int W  = sigWidth + 4 + low_expand;
    localparam int H  = sigWidth - 1 + low_expand;
    localparam int PW = $clog2(W);
    localparam int EW = expWidth + 2;
    localparam int RW = expWidth + sigWidth;
    localparam logic [EW-1:0] EMAX = EW'((1 << expWidth) - 1);

    logic [3:1] vld_q;
    logic       ld1, ld2, ld3;

    logic                s1_sign_q;
    logic [W-1:0]        s1_mag_q, mag_d;
    logic [expWidth-1:0] s1_exp_q;

    logic                s2_sign_q, s2_zero_q;
    logic [W-1:0]        s2_norm_q, norm_d;
    logic [EW-1:0]       s2_e_q, e_d;
    logic [PW-1:0]       p;

    logic [sigWidth-1:0] kept;
    logic [sigWidth-2:0] frac;
    logic                g, st, rnd, carry;
    logic [EW-1:0]       e3;
    logic [RW-1:0]       res_q, res_d;
    logic [2:0]          flg_q, flg_d;

    // A stage may load when empty or when the stage ahead of it is moving.
    assign ld3 = ~vld_q[3] | bus.out_ready;
    assign ld2 = ~vld_q[2] | ld3;
    assign ld1 = ~vld_q[1] | ld2;

    assign bus.in_ready   = ld1;
    assign bus.out_valid  = vld_q[3];
    assign bus.out_result = res_q;
    assign bus.out_flags  = flg_q;

    // S1: magnitude as W-bit unsigned, so the most-negative sum still fits.
    assign mag_d = bus.in_mantissa[W-1] ? (~bus.in_mantissa + W'(1)) : bus.in_mantissa;

    // S2: leading-one position drives both the normalising shift and the exponent.
    always_comb begin
        p = '0;
        for (int i = 0; i < W; i++) begin
            if (s1_mag_q[i]) p = PW'(i);
        end
    end

    assign norm_d = s1_mag_q << (PW'(W - 1) - p);
    assign e_d    = {2'b00, s1_exp_q} + EW'(p) - EW'(H);

    // S3: round-to-nearest-even on the normalised significand.
    assign kept  = s2_norm_q[W-1 -: sigWidth];
    assign g     = s2_norm_q[W-1-sigWidth];
    assign st    = |s2_norm_q[W-2-sigWidth:0];
    assign rnd   = g & (st | kept[0]);
    assign carry = rnd & (&kept);
    assign frac  = kept[sigWidth-2:0] + (sigWidth-1)'(rnd);
    assign e3    = s2_e_q + EW'(carry);

    always_comb begin
        res_d = {s2_sign_q, e3[expWidth-1:0], frac};
        flg_d = {2'b00, g | st};
        if (s2_zero_q) begin
            res_d = '0;
            flg_d = 3'b000;
        end else if (!e3[EW-1] && (e3 >= EMAX)) begin
            res_d = {s2_sign_q, {(expWidth-1){1'b1}}, 1'b0, {(sigWidth-1){1'b1}}};
            flg_d = 3'b101;
        end else if (e3[EW-1] || (e3 == '0)) begin
            res_d = {s2_sign_q, {(RW-1){1'b0}}};
            flg_d = 3'b011;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            s1_sign_q <= 1'b0;
            s1_mag_q  <= '0;
            s1_exp_q  <= '0;
            s2_sign_q <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_norm_q <= '0;
            s2_e_q    <= '0;
            res_q     <= '0;
            flg_q     <= '0;
        end else begin
            if (ld1) vld_q[1] <= bus.in_valid;
            if (ld2) vld_q[2] <= vld_q[1];
            if (ld3) vld_q[3] <= vld_q[2];
            if (ld1 && bus.in_valid) begin
                s1_sign_q <= bus.in_mantissa[W-1];
                s1_mag_q  <= mag_d;
                s1_exp_q  <= bus.in_exp;
            end
            if (ld2 && vld_q[1]) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= (s1_mag_q == '0);
                s2_norm_q <= norm_d;
                s2_e_q    <= e_d;
            end
            if (ld3 && vld_q[2]) begin
                res_q <= res_d;
                flg_q <= flg_d;
            end
        end
    end
endmodule

// File: tb/tb_norm_round_pipe.sv
// Directed bench for norm_round_pipe: expected {result, flags} pairs are queued as beats
// are offered and popped by an output monitor when the pipe delivers them.
`timescale 1ns/1ps
module tb_norm_round_pipe;
    localparam int W  = 10;
    localparam int NV = 18;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    norm_round_pipe_if #(.expWidth(4), .sigWidth(4), .low_expand(2)) bus ();
    norm_round_pipe #(.expWidth(4), .sigWidth(4), .low_expand(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [10:0] sb_q[$];
    logic        stalled_q = 1'b0;
    logic [10:0] prev_out  = '0;

    // {mantissa[9:0], exp[3:0], result[7:0], flags[2:0]}
    logic [24:0] vec [0:NV-1] = '{
        {10'd32,   4'd7,  8'h38, 3'b000},
        {10'd480,  4'd7,  8'h57, 3'b000},
        {10'h3E0,  4'd7,  8'hB8, 3'b000},
        {10'd38,   4'd7,  8'h3A, 3'b001},
        {10'd34,   4'd7,  8'h38, 3'b001},
        {10'd62,   4'd7,  8'h40, 3'b001},
        {10'd37,   4'd7,  8'h39, 3'b001},
        {10'd480,  4'd14, 8'h77, 3'b101},
        {10'd1,    4'd1,  8'h00, 3'b011},
        {10'd0,    4'd7,  8'h00, 3'b000},
        {10'h200,  4'd14, 8'hF7, 3'b101},
        {10'd1,    4'd5,  8'h00, 3'b011},
        {10'd1,    4'd6,  8'h08, 3'b000},
        {10'd32,   4'd14, 8'h70, 3'b000},
        {10'd32,   4'd15, 8'h77, 3'b101},
        {10'd62,   4'd14, 8'h77, 3'b101},
        {10'h3FF,  4'd1,  8'h80, 3'b011},
        {10'd0,    4'd0,  8'h00, 3'b000}
    };

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [24:0] v);
        int n = 0;
        bus.in_valid    = 1'b1;
        bus.in_mantissa = v[24:15];
        bus.in_exp      = v[14:11];
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("accept_timeout", 12'(bus.in_ready), 12'd1);
        sb_q.push_back(v[10:0]);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (sb_q.size() != 0) chk("drain_timeout", 12'(sb_q.size()), 12'd0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard pop on transfer, hold check while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_q <= 1'b0;
        end else begin
            if (stalled_q)
                chk("stall_hold", {bus.out_valid, bus.out_result, bus.out_flags}, {1'b1, prev_out});
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) chk("unexpected_beat", 12'(sb_q.size()), 12'd1);
                else chk("result", {1'b0, bus.out_result, bus.out_flags}, {1'b0, sb_q.pop_front()});
            end
            stalled_q <= bus.out_valid && !bus.out_ready;
            prev_out  <= {bus.out_result, bus.out_flags};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_mantissa = '0;
        bus.in_exp      = '0;
        bus.out_ready   = 1'b1;
        #12;
        chk("rst_out_valid",  12'(bus.out_valid),  12'd0);
        chk("rst_out_result", 12'(bus.out_result), 12'd0);
        chk("rst_out_flags",  12'(bus.out_flags),  12'd0);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 12'(bus.in_ready), 12'd1);

        // Single beat latency: valid after the third edge counting the accept edge.
        send(vec[0]);
        chk("lat_edge1", 12'(bus.out_valid), 12'd0);
        @(posedge clk); #1;
        chk("lat_edge2", 12'(bus.out_valid), 12'd0);
        @(posedge clk); #1;
        chk("lat_edge3", 12'(bus.out_valid), 12'd1);
        drain();

        for (int i = 0; i < NV; i++) send(vec[i]);
        drain();

        // Six back-to-back beats with a five-cycle consumer stall once the pipe fills.
        fork
            begin
                for (int i = 0; i < 6; i++) send(vec[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                @(posedge clk); #1;
                chk("stall_in_ready",  12'(bus.in_ready),  12'd0);
                chk("stall_out_valid", 12'(bus.out_valid), 12'd1);
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_sb_empty", 12'(sb_q.size()), 12'd0);

        // Async reset between edges with three beats in flight.
        for (int i = 3; i < 6; i++) send(vec[i]);
        chk("pre_rst_out_valid", 12'(bus.out_valid), 12'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid",  12'(bus.out_valid),  12'd0);
        chk("mid_rst_out_result", 12'(bus.out_result), 12'd0);
        chk("mid_rst_out_flags",  12'(bus.out_flags),  12'd0);
        sb_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_stale", 12'(bus.out_valid), 12'd0);
        end
        @(posedge clk); #1;
        send(vec[7]);
        chk("post_rst_edge1", 12'(bus.out_valid), 12'd0);
        @(posedge clk); #1;
        chk("post_rst_edge2", 12'(bus.out_valid), 12'd0);
        @(posedge clk); #1;
        chk("post_rst_edge3", 12'(bus.out_valid), 12'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/norm_round_pipe.md
Name: norm_round_pipe

Overview:
Downstream stage of the four-input aligned-mantissa adder in the GEMM datapath. Takes the raw two's-complement sum plus the shared maximum exponent and returns a packed float. The conversion is sign extraction, leading-one normalisation, round-to-nearest-even, then overflow saturation and underflow flush. It is a 3-stage pipeline with valid/ready handshakes on both sides.

Parameters:
expWidth, 4, exponent field width (biased, bias = 2^(expWidth-1)-1)
sigWidth, 4, significand width including hidden bit (fraction = sigWidth-1 bits)
low_expand, 2, extra low guard bits carried by the alignment/adder stages
Derived: W = sigWidth+4+low_expand (default 10); H = sigWidth-1+low_expand (default 5), the hidden-bit position of an aligned operand.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept a beat
in_mantissa  in  W  two's-complement sum; bit H has weight 2^(in_exp-bias)
in_exp  in  expWidth  biased common (max) exponent of the summed operands
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_result  out  expWidth+sigWidth  {sign, exp[expWidth], frac[sigWidth-1]}
out_flags  out  3  {overflow, underflow, inexact}

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0, out_valid=0, out_result=0, out_flags=0.
- Reset mid-stream discards every in-flight beat, with no partial output.
- Handshake:
  - A beat transfers on an edge where valid&ready.
  - Each stage k loads when it is empty or stage k+1 is loading/draining: ld_k = ~v_k | ld_{k+1}, with ld_3 = ~out_valid | out_ready.
  - in_ready = ld_1, combinational, with no dependence on in_valid.
  - Bubbles collapse.
  - out_result/out_flags are held stable while out_valid & ~out_ready.
- Latency: a beat accepted at edge t is presented with out_valid=1 after edge t+2 when there is no stall. Throughput is 1 beat/cycle. Order is preserved, with no drop or duplicate.
- S1: register sign = in_mantissa[W-1], mag = |in_mantissa| as W-bit unsigned (most-negative value fits), and in_exp.
- S2:
  - p = index of leading one of mag; norm = mag << (W-1-p).
  - e = in_exp + p - H, computed signed with expWidth+2 bits.
  - zero = (mag==0).
- S3 rounding:
  - kept = norm[W-1 -: sigWidth], g = next bit, s = OR of remaining bits.
  - Round up iff g & (s | kept[0]).
  - Carry-out of the round sets kept = 1000..0 and e = e+1.
  - inexact = g|s.
- S3 result selection, first match wins:
  - zero: result = all 0, flags = 0.
  - e >= 2^expWidth-1: overflow. Result = {sign, 2^expWidth-2, all-ones frac} (max finite), flags = 3'b101.
  - e <= 0: underflow. Result = {sign, 0, 0} (signed zero), flags = 3'b011.
  - Otherwise: result = {sign, e[expWidth-1:0], kept[sigWidth-2:0]}, flags = {0, 0, inexact}.
- The exponent-all-ones encoding is never produced.

Test Plan:
1. in_mantissa=32, in_exp=7, out_ready=1 -> out_result=0x38, out_flags=0, out_valid exactly 3rd edge after accept.
2. in_mantissa=480 (15.0 x 2^0), in_exp=7 -> 0x57; in_mantissa=0x3E0 (-32), in_exp=7 -> 0xB8, flags 0.
3. Rounding, exp 7:
   - mantissa 38 -> 0x3A, inexact=1.
   - mantissa 34 -> 0x38, inexact=1 (tie to even).
   - mantissa 62 -> 0x40, inexact=1 (carry-out, exp+1).
4. Boundaries:
   - in_exp=14, mantissa=480 -> 0x77, flags=3'b101.
   - in_exp=1, mantissa=1 -> 0x00, flags=3'b011.
   - mantissa=0 -> 0x00, flags 0.
5. Stream 6 beats back-to-back with out_ready low for 5 cycles mid-stream:
   - in_ready drops once the 3 stages are full.
   - All 6 results emerge in order, none lost or duplicated.
   - Outputs are stable during the stall.
6. Assert rst_n=0 asynchronously between edges with 3 beats in flight -> out_valid and outputs go 0 immediately. After release, no stale beats appear and the next accepted beat emerges with 3-cycle latency.
